// File: rtl/auth_pkg.sv
// ============================================================================
// auth_pkg : shared types and helpers for the authentication sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package auth_pkg;

  typedef enum logic [1:0] {
    UNSET  = 2'd0,
    ARMED  = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int DEFAULT_CODE_W = 8;

  function automatic int fail_w(input int max_fails);
    return $clog2(max_fails + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/auth_compare.sv
// ============================================================================
// auth_compare : combinational XNOR-reduce equality of two codes
// Revision     : 1.0
// ============================================================================
`default_nettype none

module auth_compare #(
  parameter int CODE_W = auth_pkg::DEFAULT_CODE_W
) (
  input  logic [CODE_W-1:0] a,
  input  logic [CODE_W-1:0] b,
  output logic              eq
);

  assign eq = &(a ~^ b);

endmodule

`default_nettype wire

// File: rtl/auth_sequencer.sv
// ============================================================================
// auth_sequencer : set/guess code sequencer with failure count and lockout
// Revision       : 1.0
// ============================================================================
`default_nettype none

module auth_sequencer
  import auth_pkg::*;
#(
  parameter int CODE_W      = DEFAULT_CODE_W,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         set_valid,
  input  logic [CODE_W-1:0]            set_code,
  input  logic                         guess_valid,
  input  logic [CODE_W-1:0]            guess_code,
  output logic                         ready,
  output logic                         matched,
  output logic                         unmatched,
  output logic                         locked,
  output logic [fail_w(MAX_FAILS)-1:0] fail_count
);

  localparam int FAIL_W  = fail_w(MAX_FAILS);
  localparam int TIMER_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [FAIL_W-1:0]  MAX_F     = FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);

  state_t              state, state_nxt;
  logic [CODE_W-1:0]   code, code_nxt;
  logic [CODE_W-1:0]   guess, guess_nxt;
  logic [FAIL_W-1:0]   fail_nxt, fail_inc;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic                matched_nxt, unmatched_nxt;
  logic                eq;

  auth_compare #(.CODE_W(CODE_W)) u_compare (
    .a  (code),
    .b  (guess),
    .eq (eq)
  );

  assign ready  = (state == ARMED);
  assign locked = (state == LOCKED);

  // Saturating increment: the count can never pass MAX_FAILS.
  assign fail_inc = (fail_count >= MAX_F) ? MAX_F : fail_count + FAIL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNSET;
      code       <= '0;
      guess      <= '0;
      fail_count <= '0;
      timer      <= '0;
      matched    <= 1'b0;
      unmatched  <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      guess      <= guess_nxt;
      fail_count <= fail_nxt;
      timer      <= timer_nxt;
      matched    <= matched_nxt;
      unmatched  <= unmatched_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    code_nxt      = code;
    guess_nxt     = guess;
    fail_nxt      = fail_count;
    timer_nxt     = timer;
    matched_nxt   = 1'b0;
    unmatched_nxt = 1'b0;
    case (state)
      UNSET: begin
        if (set_valid) begin
          code_nxt  = set_code;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        // A set request takes priority and silently drops a same-cycle guess.
        if (set_valid) begin
          code_nxt = set_code;
          fail_nxt = '0;
        end else if (guess_valid) begin
          guess_nxt = guess_code;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (eq) begin
          matched_nxt = 1'b1;
          fail_nxt    = '0;
          state_nxt   = ARMED;
        end else begin
          unmatched_nxt = 1'b1;
          fail_nxt      = fail_inc;
          if (fail_inc == MAX_F) begin
            state_nxt = LOCKED;
            timer_nxt = LOCK_LOAD;
          end else begin
            state_nxt = ARMED;
          end
        end
      end
      LOCKED: begin
        if (timer == '0) begin
          state_nxt = ARMED;
          fail_nxt  = '0;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      default: state_nxt = UNSET;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_auth_sequencer.sv
// ============================================================================
// tb_auth_sequencer : directed, table-driven bench for auth_sequencer
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_auth_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_valid;
  logic [7:0] set_code;
  logic       guess_valid;
  logic [7:0] guess_code;
  logic       ready, matched, unmatched, locked;
  logic [1:0] fail_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sv;
    logic [7:0] sc;
    logic       gv;
    logic [7:0] gc;
    logic       r;
    logic       m;
    logic       u;
    logic       l;
    int         f;
  } vec_t;

  vec_t vecs [21];

  auth_sequencer #(.CODE_W(8), .MAX_FAILS(3), .LOCK_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_valid   (set_valid),
    .set_code    (set_code),
    .guess_valid (guess_valid),
    .guess_code  (guess_code),
    .ready       (ready),
    .matched     (matched),
    .unmatched   (unmatched),
    .locked      (locked),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int r, input int m,
                         input int u, input int l, input int f);
    chk({tag, ".ready"},      int'(ready),      r);
    chk({tag, ".matched"},    int'(matched),    m);
    chk({tag, ".unmatched"},  int'(unmatched),  u);
    chk({tag, ".locked"},     int'(locked),     l);
    chk({tag, ".fail_count"}, int'(fail_count), f);
  endtask

  task automatic drive(input logic sv, input logic [7:0] sc,
                       input logic gv, input logic [7:0] gc);
    set_valid   = sv;
    set_code    = sc;
    guess_valid = gv;
    guess_code  = gc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // UNSET ignore, match, failure-clear-on-success, set-beats-guess,
    // set clears count, CHECK ignores inputs.
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b1, 8'h11, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[16] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[18] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0};

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].sv, vecs[i].sc, vecs[i].gv, vecs[i].gc);
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].r), int'(vecs[i].m),
              int'(vecs[i].u), int'(vecs[i].l), vecs[i].f);
    end

    // Lockout: stored code is 0x5A; three wrong guesses.
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(g));
      tick();
      chk_all($sformatf("lock_g%0d_chk", g), 0, 0, 0, 0, g);
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      tick();
      chk_all($sformatf("lock_g%0d_res", g), (g == 2) ? 0 : 1, 0, 1,
              (g == 2) ? 1 : 0, g + 1);
    end
    // First LOCKED cycle checked above; 15 more with correct guess and set ignored.
    for (int c = 2; c <= 16; c++) begin
      drive(1'b1, 8'hFF, 1'b1, 8'h5A);
      tick();
      chk_all($sformatf("locked_c%0d", c), 0, 0, 0, 1, 3);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk_all("unlock", 1, 0, 0, 0, 0);
    drive(1'b0, 8'h00, 1'b1, 8'h5A);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk_all("post_lock_match", 1, 1, 0, 0, 0);

    // Reset mid-lock.
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 8'h00, 1'b1, 8'hC3);
      tick();
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      tick();
    end
    tick();
    chk_all("relock", 0, 0, 0, 1, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 8'h00);
    tick();
    chk_all("unset_ign0", 0, 0, 0, 0, 0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk_all("unset_ign1", 0, 0, 0, 0, 0);
    // Stored code was cleared to 0 by reset; a 0x00 guess after set 0x77 must miss.
    drive(1'b1, 8'h77, 1'b0, 8'h00);
    tick();
    chk_all("reset_set", 1, 0, 0, 0, 0);
    drive(1'b0, 8'h00, 1'b1, 8'h00);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk_all("reset_miss", 1, 0, 1, 0, 1);
    drive(1'b0, 8'h00, 1'b1, 8'h77);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk_all("reset_hit", 1, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/auth_sequencer.md
Name: auth_sequencer

Overview:
- Sequencing controller for the 8-bit setter/guesser authentication datapath.
- The setter programs a stored code; the guesser submits attempts; the block compares each attempt and issues one-cycle matched/unmatched pulses.
- It counts consecutive failures and enforces a timed lockout.
- It sits between the user-facing code entry logic and the XNOR-equality comparator.

Parameters:
- CODE_W, 8, width of the stored code and of each guess.
- MAX_FAILS, 3, consecutive mismatches that trigger lockout (legal range >= 1).
- LOCK_CYCLES, 16, number of cycles spent in LOCKED (legal range >= 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- set_valid  in  1  load set_code as the new stored code.
- set_code  in  CODE_W  code supplied by the setter.
- guess_valid  in  1  submit guess_code; accepted only while ready=1.
- guess_code  in  CODE_W  code supplied by the guesser.
- ready  out  1  block is in ARMED and will accept a guess.
- matched  out  1  one-cycle pulse: the evaluated guess equals the stored code.
- unmatched  out  1  one-cycle pulse: the evaluated guess differs from the stored code.
- locked  out  1  high for the whole of LOCKED.
- fail_count  out  $clog2(MAX_FAILS+1)  current consecutive-failure count.

Behaviour:
- Reset:
  - Asynchronous assert on rst_n=0, regardless of clk.
  - state=UNSET, stored code=0, guess register=0, fail_count=0, lock timer=0.
  - ready=0, matched=0, unmatched=0, locked=0.
  - Release is synchronous to clk.
- States: UNSET, ARMED, CHECK, LOCKED. All outputs are registered or decoded directly from state.
- UNSET:
  - guess_valid is ignored: no pulse, no count change.
  - set_valid=1 loads set_code and moves to ARMED on the next edge.
- ARMED (ready=1):
  - set_valid=1 reloads the code, clears fail_count and stays in ARMED.
  - guess_valid=1 with set_valid=0 captures guess_code and moves to CHECK.
  - If set_valid and guess_valid are both 1, set wins and the guess is dropped; no pulse is produced for it.
- CHECK (ready=0):
  - Both set_valid and guess_valid are ignored.
  - Equality = AND-reduction of XNOR(stored, guess).
  - On match: matched=1 for exactly the following cycle, fail_count cleared to 0, next state ARMED.
  - On mismatch: unmatched=1 for exactly the following cycle, fail_count increments.
  - If the incremented count equals MAX_FAILS: next state LOCKED, lock timer loaded with LOCK_CYCLES-1. Otherwise next state ARMED.
  - matched and unmatched are never both high.
- Latency:
  - Guess sampled at edge N; the compare is registered at edge N+1.
  - The pulse is visible in the cycle after edge N+1.
  - ready returns to 1 in that same cycle, so back-to-back guesses are accepted every 2 cycles.
- LOCKED:
  - locked=1, ready=0. All set and guess inputs are ignored.
  - fail_count holds MAX_FAILS.
  - The timer decrements each cycle. At timer=0 the next edge moves to ARMED, clears fail_count and drops locked.
  - LOCKED therefore lasts exactly LOCK_CYCLES cycles. The stored code is retained.
- Saturation: fail_count never exceeds MAX_FAILS. The timer never underflows.
- Reset mid-operation: reset in any state, including CHECK and LOCKED, returns to UNSET. Any pending pulse is cancelled and the stored code is lost.
- MAX_FAILS=1: the first mismatch locks immediately.

Decomposition:
- Package auth_pkg:
  - state enum {UNSET, ARMED, CHECK, LOCKED}.
  - Default CODE_W.
  - Fail-count width function.
- Sub-module auth_compare: a purely combinational, CODE_W-wide XNOR-reduce equality. It reuses the existing comparator datapath and is instantiated once inside the sequencer.

Test Plan:
- Reset and pre-set: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Release, pulse guess_valid with 0x3C -> no matched/unmatched, state stays UNSET, ready=0.
- Match: set_code=0xA5, then guess 0xA5 at edge N -> matched=1 for one cycle after edge N+1. fail_count=0, ready=1 in that same cycle.
- Lockout: stored 0xA5, guesses 0x00, 0x01, 0x02 -> three unmatched pulses, fail_count goes 1, 2, 3. locked=1 for exactly 16 cycles; a guess of 0xA5 during lock produces no pulse. Afterwards ready=1 and fail_count=0.
- Failure reset on success: two wrong guesses then 0xA5 -> fail_count goes 1, 2, 0. No lock occurs.
- Simultaneous set and guess in ARMED: set_code=0x5A with guess_code=0xA5 -> code reloaded, no pulse, state ARMED. A following guess of 0x5A -> matched.
- Reset mid-lock: during LOCKED, assert rst_n=0 -> locked=0 and state UNSET. After release, a guess is ignored until set_valid loads a new code.
